axi_store_grant_ctrl: RTL and testbench

Transaction-level grant controller for the two-master AXI write (store) bus. It arbitrates `m0_req`/`m1_req` and holds the grant for one complete AXI write transaction: AW handshake, all W beats through `wlast`, and the B handshake. It also checks the W beat count against the captured `awlen`. It sits beside the store-bus master mux and drives its `m0_grnt`/`m1_grnt` selects, while observing handshakes on the shared (slave-side) write channels.

---
 rtl/axi_store_grant_ctrl_if.sv | 40 ++++
 rtl/axi_store_grant_ctrl.sv | 132 +++++++++++++
 tb/tb_axi_store_grant_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_store_grant_ctrl_if.sv
// Bundle of the two-master store-bus request/grant lines and the shared
// slave-side write-channel handshakes that the grant controller observes.
interface axi_store_grant_ctrl_if;
  // Handshake rule on every channel: a transfer happens on a rising clock
  // edge where valid and ready are both high. The controller only observes
  // these handshakes. It never drives valid or ready.
  logic       m0_req;
  logic       m1_req;
  logic       m0_grnt;
  logic       m1_grnt;
  logic       awvalid;
  logic       awready;
  logic [3:0] awlen;
  logic       wvalid;
  logic       wready;
  logic       wlast;
  logic       bvalid;
  logic       bready;
  logic       busy;
  logic       owner;
  logic       len_err;

  // The controller side.
  modport slave (
    input  m0_req, m1_req,
    input  awvalid, awready, awlen,
    input  wvalid, wready, wlast,
    input  bvalid, bready,
    output m0_grnt, m1_grnt, busy, owner, len_err
  );

  // The side that drives requests and the bus (masters, mux, slave).
  modport master (
    output m0_req, m1_req,
    output awvalid, awready, awlen,
    output wvalid, wready, wlast,
    output bvalid, bready,
    input  m0_grnt, m1_grnt, busy, owner, len_err
  );
endinterface

// File: rtl/axi_store_grant_ctrl.sv
// Transaction-level grant controller for the two-master AXI store bus.
// STORE_ARB_RR_EN selects round-robin arbitration. Fixed m0 priority is used otherwise.
module axi_store_grant_ctrl #(
  parameter int BEAT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_store_grant_ctrl_if.slave bus,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [BEAT_W-1:0] BEAT_ONE = {{(BEAT_W-1){1'b0}}, 1'b1};
  localparam logic [BEAT_W-1:0] BEAT_MAX = {BEAT_W{1'b1}};

  state_t            r_state;
  logic              r_m0_grnt;
  logic              r_m1_grnt;
  logic              r_busy;
  logic              r_owner;
  logic              r_len_err;
  logic              r_aw_done;
  logic              r_w_done;
  logic [3:0]        r_len_q;
  logic [BEAT_W-1:0] r_beats;

  logic              w_any_req;
  logic              w_pick_m1;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;
  logic              w_aw_first;
  logic              w_aw_done_nxt;
  logic              w_w_done_nxt;
  logic [3:0]        w_len_nxt;
  logic [BEAT_W-1:0] w_beats_nxt;
  logic [BEAT_W-1:0] w_exp_beats;
  logic              w_both_done;

  assign w_any_req = bus.m0_req | bus.m1_req;

`ifdef STORE_ARB_RR_EN
  // On a tie, the master that did not hold the last grant wins.
  assign w_pick_m1 = bus.m1_req & (~bus.m0_req | ~r_owner);
`else
  assign w_pick_m1 = bus.m1_req & ~bus.m0_req;
`endif

  assign w_aw_hs = bus.awvalid & bus.awready;
  assign w_w_hs  = bus.wvalid & bus.wready;
  assign w_b_hs  = bus.bvalid & bus.bready;

  // Only the first AW handshake of a grant is taken. Later ones are ignored.
  assign w_aw_first    = w_aw_hs & ~r_aw_done;
  assign w_aw_done_nxt = r_aw_done | w_aw_hs;
  assign w_len_nxt     = w_aw_first ? bus.awlen : r_len_q;
  assign w_w_done_nxt  = r_w_done | (w_w_hs & bus.wlast);
  assign w_beats_nxt   = (w_w_hs && (r_beats != BEAT_MAX)) ? (r_beats + BEAT_ONE)
                                                           : r_beats;
  assign w_exp_beats   = {{(BEAT_W-4){1'b0}}, w_len_nxt} + BEAT_ONE;
  assign w_both_done   = w_aw_done_nxt & w_w_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_m0_grnt <= 1'b0;
      r_m1_grnt <= 1'b0;
      r_busy    <= 1'b0;
      r_owner   <= 1'b1;
      r_len_err <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_len_q   <= 4'd0;
      r_beats   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state   <= S_XFER;
            r_m0_grnt <= ~w_pick_m1;
            r_m1_grnt <= w_pick_m1;
            r_owner   <= w_pick_m1;
            r_busy    <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_beats   <= '0;
          end
        end
        S_XFER: begin
          r_aw_done <= w_aw_done_nxt;
          r_w_done  <= w_w_done_nxt;
          r_len_q   <= w_len_nxt;
          r_beats   <= w_beats_nxt;
          // AW and W may finish in either order or together.
          if (w_both_done) begin
            r_state <= S_RESP;
            if (w_beats_nxt != w_exp_beats) begin
              r_len_err <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (w_b_hs) begin
            r_state   <= S_IDLE;
            r_m0_grnt <= 1'b0;
            r_m1_grnt <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_m0_grnt <= 1'b0;
          r_m1_grnt <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m0_grnt = r_m0_grnt;
  assign bus.m1_grnt = r_m1_grnt;
  assign bus.busy    = r_busy;
  assign bus.owner   = r_owner;
  assign bus.len_err = r_len_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_store_grant_ctrl.sv
// Self-checking bench for axi_store_grant_ctrl: randomized transactions checked
// against a transaction-level model of arbitration, grant hold and length checking.
module tb_axi_store_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  // Model state: last winner (1 = m1) and the sticky length error.
  bit         m_owner = 1'b1;
  bit         m_len_err = 1'b0;
  logic [1:0] exp_q[$];

`ifdef STORE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  axi_store_grant_ctrl_if bus();

  axi_store_grant_ctrl #(.BEAT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.awvalid = 1'b0;
    bus.awready = 1'b0;
    bus.awlen   = 4'd0;
    bus.wvalid  = 1'b0;
    bus.wready  = 1'b0;
    bus.wlast   = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bready  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    idle_bus();
    repeat (2) tick();
    rst_n = 1'b1;
    m_owner = 1'b1;
    m_len_err = 1'b0;
    exp_q.delete();
    tick();
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] model_grant(input bit r0, input bit r1);
    bit w;
    if (r0 && r1) w = RR ? ~m_owner : 1'b0;
    else          w = r1;
    return w ? 2'b10 : 2'b01;
  endfunction

  // ---------------- driver ----------------
  // The task runs one full transaction from IDLE and checks the grant at every
  // cycle. Setting w_first delays AW until all W beats are done. Setting stray
  // adds B handshakes while AW is still pending, and these must not release the grant.
  task automatic run_txn(input bit r0, input bit r1, input int awlen, input int nbeats,
                         input bit w_first, input bit drop, input int b_stall,
                         input bit stray, output bit who);
    logic [1:0] exp_g;
    logic [1:0] got;
    int         sent;
    int         cyc;
    bit         aw_done;
    bit         w_hs;
    bit         aw_hs;
    bus.m0_req = r0;
    bus.m1_req = r1;
    exp_q.push_back(model_grant(r0, r1));
    tick();
    got   = {bus.m1_grnt, bus.m0_grnt};
    exp_g = exp_q.pop_front();
    who   = exp_g[1];
    checks++;
    if (got !== exp_g) begin
      errors++;
      $display("FAIL grant_select got=%b exp=%b", got, exp_g);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_on_grant got=%b exp=1", bus.busy);
    end
    m_owner = exp_g[1];
    who = got[1];
    if (drop) begin
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
    end
    sent = 0;
    cyc = 0;
    aw_done = 1'b0;
    while ((sent < nbeats || !aw_done) && cyc < 400) begin
      idle_bus();
      if (sent < nbeats) begin
        bus.wvalid = ($urandom_range(0, 3) != 0);
        bus.wready = ($urandom_range(0, 3) != 0);
        bus.wlast  = (sent == nbeats - 1);
      end
      if (!aw_done && (!w_first || sent == nbeats)) begin
        bus.awvalid = ($urandom_range(0, 2) != 0);
        bus.awready = ($urandom_range(0, 2) != 0);
        bus.awlen   = awlen[3:0];
      end else if (aw_done && sent < nbeats && $urandom_range(0, 3) == 0) begin
        bus.awvalid = 1'b1;
        bus.awready = 1'b1;
        bus.awlen   = ~awlen[3:0];
      end
      if (stray && !aw_done) begin
        bus.bvalid = 1'b1;
        bus.bready = 1'b1;
      end
      w_hs  = bus.wvalid & bus.wready;
      aw_hs = !aw_done && bus.awvalid && bus.awready;
      tick();
      if (w_hs) sent++;
      if (aw_hs) aw_done = 1'b1;
      cyc++;
      got = {bus.m1_grnt, bus.m0_grnt};
      checks++;
      if (got !== exp_g) begin
        errors++;
        $display("FAIL grant_held_xfer cyc=%0d got=%b exp=%b", cyc, got, exp_g);
      end
    end
    if (cyc >= 400) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout sent=%0d aw_done=%0d", sent, aw_done);
    end
    if (nbeats != awlen + 1) m_len_err = 1'b1;
    checks++;
    if (bus.len_err !== m_len_err) begin
      errors++;
      $display("FAIL len_err_resp got=%b exp=%b", bus.len_err, m_len_err);
    end
    idle_bus();
    for (int i = 0; i < b_stall; i++) begin
      bus.bvalid = 1'b1;
      bus.bready = 1'b0;
      tick();
      got = {bus.m1_grnt, bus.m0_grnt};
      checks++;
      if (got !== exp_g) begin
        errors++;
        $display("FAIL grant_held_bstall got=%b exp=%b", got, exp_g);
      end
    end
    bus.bvalid = 1'b1;
    bus.bready = 1'b1;
    tick();
    idle_bus();
    got = {bus.m1_grnt, bus.m0_grnt};
    checks++;
    if (got !== 2'b00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL release got=%b busy=%b exp=00 busy=0", got, bus.busy);
    end
    checks++;
    if (bus.owner !== m_owner || bus.len_err !== m_len_err) begin
      errors++;
      $display("FAIL status_after owner=%b len_err=%b exp owner=%b len_err=%b",
               bus.owner, bus.len_err, m_owner, m_len_err);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.m0_grnt !== 1'b0 || bus.m1_grnt !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_grant g=%b%b busy=%b exp=00/0", bus.m1_grnt, bus.m0_grnt, bus.busy);
    end
    checks++;
    if (bus.owner !== 1'b1 || bus.len_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status owner=%b len_err=%b exp=1/0", bus.owner, bus.len_err);
    end
    tick();
    checks++;
    if ({bus.m1_grnt, bus.m0_grnt} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_req got=%b exp=00", {bus.m1_grnt, bus.m0_grnt});
    end
  endtask

  task automatic test_basic();
    bit who;
    run_txn(1'b1, 1'b0, 3, 4, 1'b0, 1'b0, 0, 1'b0, who);
    bus.m0_req = 1'b0;
    tick();
  endtask

  task automatic test_rr_order();
    bit who;
    bit exp_who[3];
    do_reset();
    exp_who[0] = 1'b0;
    exp_who[1] = RR;
    exp_who[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 0, 1'b0, who);
      checks++;
      if (who !== exp_who[i]) begin
        errors++;
        $display("FAIL tie_order txn=%0d got=m%0d exp=m%0d", i, who, exp_who[i]);
      end
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick();
  endtask

  task automatic test_w_first();
    bit who;
    run_txn(1'b1, 1'b0, 1, 2, 1'b1, 1'b0, 0, 1'b1, who);
    bus.m0_req = 1'b0;
    tick();
  endtask

  task automatic test_len_err();
    bit who;
    run_txn(1'b0, 1'b1, 3, 2, 1'b0, 1'b1, 0, 1'b0, who);
    run_txn(1'b1, 1'b0, 2, 3, 1'b0, 1'b1, 1, 1'b0, who);
    run_txn(1'b1, 1'b1, 0, 1, 1'b1, 1'b1, 0, 1'b0, who);
    tick();
  endtask

  task automatic test_req_drop();
    bit who;
    do_reset();
    run_txn(1'b0, 1'b1, 2, 3, 1'b0, 1'b1, 3, 1'b0, who);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.m0_req = 1'b1;
    tick();
    checks++;
    if ({bus.m1_grnt, bus.m0_grnt} !== 2'b01) begin
      errors++;
      $display("FAIL min_grant got=%b exp=01", {bus.m1_grnt, bus.m0_grnt});
    end
    // A single-beat write with awlen=1 produces a length error before reset.
    bus.awvalid = 1'b1;
    bus.awready = 1'b1;
    bus.awlen   = 4'd1;
    bus.wvalid  = 1'b1;
    bus.wready  = 1'b1;
    bus.wlast   = 1'b1;
    tick();
    idle_bus();
    checks++;
    if ({bus.m1_grnt, bus.m0_grnt} !== 2'b01 || bus.len_err !== 1'b1) begin
      errors++;
      $display("FAIL resp_entry g=%b len_err=%b exp=01/1", {bus.m1_grnt, bus.m0_grnt}, bus.len_err);
    end
    bus.bvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.m1_grnt, bus.m0_grnt} !== 2'b00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset g=%b busy=%b exp=00/0", {bus.m1_grnt, bus.m0_grnt}, bus.busy);
    end
    checks++;
    if (bus.owner !== 1'b1 || bus.len_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_status owner=%b len_err=%b exp=1/0", bus.owner, bus.len_err);
    end
    bus.m0_req = 1'b0;
    idle_bus();
    tick();
    rst_n = 1'b1;
    m_owner = 1'b1;
    m_len_err = 1'b0;
    tick();
    test_basic();
  endtask

  task automatic test_random();
    bit who;
    int r;
    int len;
    int nb;
    for (int i = 0; i < 25; i++) begin
      r   = $urandom_range(1, 3);
      len = $urandom_range(0, 15);
      nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : len + 1;
      run_txn(r[0], r[1], len, nb, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2), 1'b0, who);
      if ($urandom_range(0, 1) == 1) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        tick();
      end
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    idle_bus();
    test_reset();
    test_basic();
    test_rr_order();
    test_w_first();
    test_len_err();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
